// File: rtl/icap_stream_ctrl.sv
// AXI-stream to ICAPE3 bitstream writer: each 64-bit beat becomes one or two
// 32-bit ICAP words (low word first), with error, timeout and abort handling.
module icap_stream_ctrl #(
  parameter int BIT_SWAP = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic        AxiBusClock,
  input  logic        xAxiBusReset,
  input  logic [63:0] xS_tdata,
  input  logic [7:0]  xS_tkeep,
  input  logic        xS_tlast,
  input  logic        xS_tvalid,
  output logic        xS_tready,
  input  logic        xEnable,
  input  logic        xAbort,
  input  logic        xClearErr,
  input  logic        xIcapAvail,
  input  logic        xIcapPrError,
  output logic        xIcapCsib,
  output logic        xIcapRdWrB,
  output logic [31:0] xIcapData,
  output logic        xBusy,
  output logic        xDone,
  output logic        xError,
  output logic [1:0]  xErrCode,
  output logic [31:0] xWordCount
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_LO = 3'd1,
    S_WR_HI = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       beat_data_q, beat_data_d;
  logic [7:0]        beat_keep_q, beat_keep_d;
  logic              beat_last_q, beat_last_d;
  logic              csib_q, csib_d;
  logic [31:0]       icap_data_q, icap_data_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              new_frame_q, new_frame_d;

  logic              tready;
  logic              hs;
  logic              frame_start;
  logic              err_set;
  logic [1:0]        err_code_new;
  logic              go_drain;
  logic              keep_bad;
  logic [31:0]       word_sel;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8 + i] = w[b*8 + 7 - i];
      end
    end
    return (BIT_SWAP != 0) ? r : w;
  endfunction

  always_comb begin
    state_d      = state_q;
    beat_data_d  = beat_data_q;
    beat_keep_d  = beat_keep_q;
    beat_last_d  = beat_last_q;
    csib_d       = 1'b1;
    icap_data_d  = icap_data_q;
    to_cnt_d     = '0;
    new_frame_d  = new_frame_q;
    frame_start  = 1'b0;
    err_set      = 1'b0;
    err_code_new = 2'b00;
    go_drain     = 1'b0;
    keep_bad     = 1'b0;
    word_sel     = (state_q == S_WR_HI) ? beat_data_q[63:32] : beat_data_q[31:0];

    // Mid-frame beats are accepted even after xEnable drops.
    tready = !xAxiBusReset &&
             (((state_q == S_IDLE) && !err_q && (xEnable || !new_frame_q)) ||
              (state_q == S_DRAIN));
    hs = xS_tvalid && tready;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          beat_data_d = xS_tdata;
          beat_keep_d = xS_tkeep;
          beat_last_d = xS_tlast;
          state_d     = S_WR_LO;
          if (new_frame_q) begin
            new_frame_d = 1'b0;
            frame_start = 1'b1;
          end
        end
      end
      S_WR_LO, S_WR_HI: begin
        keep_bad = (state_q == S_WR_LO) &&
                   !((beat_keep_q == 8'hFF) || ((beat_keep_q == 8'h0F) && beat_last_q));
        if (xIcapPrError) begin
          err_set      = 1'b1;
          err_code_new = 2'b01;
          go_drain     = 1'b1;
        end else if (keep_bad) begin
          err_set      = 1'b1;
          err_code_new = 2'b11;
          go_drain     = 1'b1;
        end else if (!xIcapAvail && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
          err_set      = 1'b1;
          err_code_new = 2'b10;
          go_drain     = 1'b1;
        end else if (xAbort) begin
          go_drain = 1'b1;
        end else if (xIcapAvail) begin
          csib_d      = 1'b0;
          icap_data_d = swap32(word_sel);
          if (state_q == S_WR_LO) begin
            state_d = (beat_keep_q == 8'hFF) ? S_WR_HI : S_DONE;
          end else begin
            state_d = beat_last_q ? S_DONE : S_IDLE;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        if (xIcapPrError) begin
          err_set      = 1'b1;
          err_code_new = 2'b01;
        end
        new_frame_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_DRAIN: begin
        if (xIcapPrError) begin
          err_set      = 1'b1;
          err_code_new = 2'b01;
        end
        new_frame_d = 1'b1;
        if (hs && xS_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A beat that already carried tlast has nothing left to drain.
    if (go_drain) begin
      new_frame_d = 1'b1;
      state_d     = beat_last_q ? S_IDLE : S_DRAIN;
    end

    if (err_set) begin
      err_d      = 1'b1;
      err_code_d = err_code_new;
    end else if (xClearErr) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end

    if (frame_start) begin
      word_cnt_d = '0;
    end else if (!csib_q && (word_cnt_q != 32'hFFFF_FFFF)) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  always_ff @(posedge AxiBusClock or posedge xAxiBusReset) begin
    if (xAxiBusReset) begin
      state_q     <= S_IDLE;
      csib_q      <= 1'b1;
      icap_data_q <= '0;
      word_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      new_frame_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      csib_q      <= csib_d;
      icap_data_q <= icap_data_d;
      word_cnt_q  <= word_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      new_frame_q <= new_frame_d;
    end
  end

  // Beat holding register: pure data, qualified by state.
  always_ff @(posedge AxiBusClock) begin
    beat_data_q <= beat_data_d;
    beat_keep_q <= beat_keep_d;
    beat_last_q <= beat_last_d;
  end

  assign xS_tready  = tready;
  assign xIcapCsib  = csib_q;
  assign xIcapRdWrB = 1'b0;
  assign xIcapData  = icap_data_q;
  assign xBusy      = (state_q != S_IDLE);
  assign xDone      = (state_q == S_DONE);
  assign xError     = err_q;
  assign xErrCode   = err_code_q;
  assign xWordCount = word_cnt_q;

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// Scoreboard bench for icap_stream_ctrl: expected ICAP words are queued as
// beats are driven and popped whenever the DUT writes (xIcapCsib low).
module tb_icap_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        enable;
  logic        abort_p;
  logic        clear_err;
  logic        avail;
  logic        prerror;
  logic        csib;
  logic        rdwrb;
  logic [31:0] icap_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] word_count;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          done_saved;

  icap_stream_ctrl #(.BIT_SWAP(1), .TIMEOUT(1024)) dut (
    .AxiBusClock (clk),
    .xAxiBusReset(rst),
    .xS_tdata    (tdata),
    .xS_tkeep    (tkeep),
    .xS_tlast    (tlast),
    .xS_tvalid   (tvalid),
    .xS_tready   (tready),
    .xEnable     (enable),
    .xAbort      (abort_p),
    .xClearErr   (clear_err),
    .xIcapAvail  (avail),
    .xIcapPrError(prerror),
    .xIcapCsib   (csib),
    .xIcapRdWrB  (rdwrb),
    .xIcapData   (icap_data),
    .xBusy       (busy),
    .xDone       (done),
    .xError      (error),
    .xErrCode    (err_code),
    .xWordCount  (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8 + 7 - i] = w[b*8 + i];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (csib === 1'b0) begin
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("icap_data", 64'(icap_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tready_wait", 64'(tready), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input int nexp);
    if (nexp >= 1) exp_q.push_back(ref_swap(d[31:0]));
    if (nexp >= 2) exp_q.push_back(ref_swap(d[63:32]));
    wait_ready();
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    enable = 1'b1; abort_p = 1'b0; clear_err = 1'b0; avail = 1'b1; prerror = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_csib", 64'(csib), 64'd1);
    chk("rst_data", 64'(icap_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rdwrb", 64'(rdwrb), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two full beats, known sync word.
    exp_q.push_back(32'h5599AA66);
    exp_q.push_back(32'h0000_0080);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    send_beat(64'h00000001_AA995566, 8'hFF, 1'b0, 0);
    send_beat(64'h0, 8'hFF, 1'b1, 0);
    wait_idle();
    chk("t1_wc", 64'(word_count), 64'd4);
    chk("t1_done", 64'(done_cnt), 64'd1);

    // Half last beat; enable drops mid-frame.
    send_beat(64'h12345678_9ABCDEF0, 8'hFF, 1'b0, 2);
    enable = 1'b0;
    send_beat(64'hDEADBEEF_0F1E2D3C, 8'h0F, 1'b1, 1);
    wait_idle();
    chk("t2_wc", 64'(word_count), 64'd3);
    chk("t2_done", 64'(done_cnt), 64'd2);
    @(negedge clk);
    chk("t2_enable_block", 64'(tready), 64'd0);
    enable = 1'b1;

    // Timeout in WR_HI.
    send_beat(64'hCAFEF00D_11223344, 8'hFF, 1'b0, 1);
    @(posedge clk);
    #1;
    avail = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("to_early_err", 64'(error), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("to_err", 64'(error), 64'd1);
    chk("to_code", 64'(err_code), 64'd2);
    chk("to_drain_busy", 64'(busy), 64'd1);
    chk("to_wc", 64'(word_count), 64'd1);
    avail = 1'b1;
    send_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0, 0);
    chk("to_drain_mid", 64'(busy), 64'd1);
    send_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1, 0);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_tready_blocked", 64'(tready), 64'd0);
    pulse_clear();
    chk("to_cleared", 64'(error), 64'd0);
    chk("to_code_cleared", 64'(err_code), 64'd0);
    chk("to_tready_back", 64'(tready), 64'd1);

    // Illegal tkeep mid-frame.
    send_beat(64'h01020304_05060708, 8'hFF, 1'b0, 2);
    send_beat(64'hFFFF0000_FFFF0000, 8'h3C, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("keep_err", 64'(error), 64'd1);
    chk("keep_code", 64'(err_code), 64'd3);
    chk("keep_drain", 64'(busy), 64'd1);
    send_beat(64'h0, 8'hFF, 1'b1, 0);
    pulse_clear();

    // PRERROR while stalled in WR_LO on a tlast beat.
    avail = 1'b0;
    send_beat(64'hABCDABCD_ABCDABCD, 8'hFF, 1'b1, 0);
    prerror = 1'b1;
    @(posedge clk);
    #1;
    prerror = 1'b0;
    chk("prerr_code", 64'(err_code), 64'd1);
    chk("prerr_idle", 64'(busy), 64'd0);
    pulse_clear();
    avail = 1'b1;

    // PRERROR and bad tkeep together: PRERROR wins.
    prerror = 1'b1;
    send_beat(64'h77777777_77777777, 8'h3C, 1'b1, 0);
    @(posedge clk);
    #1;
    prerror = 1'b0;
    chk("prio_code", 64'(err_code), 64'd1);
    pulse_clear();

    // Abort during WR_LO of beat 2 of 4.
    done_saved = done_cnt;
    send_beat(64'h11111111_22222222, 8'hFF, 1'b0, 2);
    wait_ready();
    avail = 1'b0;
    send_beat(64'h33333333_44444444, 8'hFF, 1'b0, 0);
    abort_p = 1'b1;
    @(posedge clk);
    #1;
    abort_p = 1'b0;
    avail = 1'b1;
    chk("abort_drain", 64'(busy), 64'd1);
    send_beat(64'h55555555_66666666, 8'hFF, 1'b0, 0);
    send_beat(64'h77777777_88888888, 8'hFF, 1'b1, 0);
    chk("abort_err", 64'(error), 64'd0);
    chk("abort_wc", 64'(word_count), 64'd2);
    chk("abort_nodone", 64'(done_cnt), 64'(done_saved));
    send_beat(64'h9999AAAA_BBBBCCCC, 8'hFF, 1'b1, 2);
    wait_idle();
    chk("restart_wc", 64'(word_count), 64'd2);

    // Reset while a write is on the bus.
    send_beat(64'hDDDDDDDD_EEEEEEEE, 8'hFF, 1'b1, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_csib", 64'(csib), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_csib_now", 64'(csib), 64'd1);
    chk("rst_busy_now", 64'(busy), 64'd0);
    chk("rst_tready_now", 64'(tready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_beat(64'h0BADF00D_FEEDFACE, 8'hFF, 1'b1, 2);
    wait_idle();
    chk("post_rst_wc", 64'(word_count), 64'd2);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
